// File: rtl/ula_dram_pkg.sv
// ula_dram_pkg: shared types and default sizing for the contended DRAM
// arbiter (sequencer states, DRAM cycle types, default widths).
package ula_dram_pkg;

    localparam int DEF_AW         = 14;
    localparam int DEF_STREAK_MAX = 2;

    typedef enum logic [2:0] {
        IDLE,
        ROW,
        RAS,
        CAS1,
        CAS2,
        PRE
    } state_t;

    typedef enum logic [2:0] {
        CYC_NONE,
        CYC_VID,
        CYC_CPU_RD,
        CYC_CPU_WR,
        CYC_RFSH
    } cycle_t;

    function automatic logic is_cpu(cycle_t c);
        return (c == CYC_CPU_RD) || (c == CYC_CPU_WR);
    endfunction

endpackage

// File: rtl/ula_dram_if.sv
// ula_dram_if: request pads (video sequencer, Z80) and DRAM pad bundle.
// slave = arbiter side, master = pad/sequencer side.
interface ula_dram_if #(
    parameter int AW = ula_dram_pkg::DEF_AW
);
    logic              vid_req;
    logic [AW-1:0]     vid_addr;
    logic              vid_ack;
    logic              vid_strobe;
    logic              n_mreq;
    logic              n_rd;
    logic              n_wr;
    logic              n_rfsh;
    logic              cpu_ram_sel;
    logic [AW-1:0]     cpu_addr;
    logic              cpu_wait;
    logic              cpu_strobe;
    logic [AW/2-1:0]   ma;
    logic              n_ras;
    logic              n_cas;
    logic              n_we;

    modport slave (
        input  vid_req, vid_addr, n_mreq, n_rd, n_wr, n_rfsh, cpu_ram_sel, cpu_addr,
        output vid_ack, vid_strobe, cpu_wait, cpu_strobe, ma, n_ras, n_cas, n_we
    );

    modport master (
        output vid_req, vid_addr, n_mreq, n_rd, n_wr, n_rfsh, cpu_ram_sel, cpu_addr,
        input  vid_ack, vid_strobe, cpu_wait, cpu_strobe, ma, n_ras, n_cas, n_we
    );
endinterface

// File: rtl/ula_dram_grant.sv
// ula_dram_grant: picks the next DRAM cycle at each decision point
// (IDLE/PRE). Video normally wins; after STREAK_MAX back-to-back video
// grants a waiting CPU gets one cycle. Refresh only fills empty slots.
module ula_dram_grant
    import ula_dram_pkg::*;
#(
    parameter int STREAK_MAX = DEF_STREAK_MAX
) (
    input  logic   clk,
    input  logic   n_rst,
    input  logic   decide,
    input  logic   vid_req,
    input  logic   cpu_req,
    input  logic   cpu_wr,
    input  logic   rfsh_req,
    output cycle_t grant
);
    localparam int SW = $clog2(STREAK_MAX + 1);

    logic [SW-1:0] streak_q, streak_d;
    logic          cpu_turn;

    // priority select; nothing is granted outside a decision point
    always_comb begin
        cpu_turn = cpu_req && (streak_q == SW'(STREAK_MAX));
        grant    = CYC_NONE;
        if (decide) begin
            if (cpu_turn)      grant = cpu_wr ? CYC_CPU_WR : CYC_CPU_RD;
            else if (vid_req)  grant = CYC_VID;
            else if (cpu_req)  grant = cpu_wr ? CYC_CPU_WR : CYC_CPU_RD;
            else if (rfsh_req) grant = CYC_RFSH;
        end
    end

    // streak: saturating count of video grants, cleared by any other outcome
    always_comb begin
        streak_d = streak_q;
        if (decide) begin
            if (grant == CYC_VID) begin
                if (streak_q != SW'(STREAK_MAX)) streak_d = streak_q + 1'b1;
            end else begin
                streak_d = '0;
            end
        end
    end

    // streak register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) streak_q <= '0;
        else        streak_q <= streak_d;
    end

endmodule

// File: rtl/ula_dram_arbiter.sv
// ula_dram_arbiter: shares the 16K contended DRAM between the video fetch
// sequencer and the Z80. Every access is ROW-RAS-CAS1-CAS2-PRE; all pad
// outputs are registered and reflect the state being entered.
// Build option: define ULA_DRAM_REFRESH_EN to turn Z80 refresh MREQs into
// RAS-only refresh cycles; otherwise n_rfsh is ignored.
module ula_dram_arbiter
    import ula_dram_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int STREAK_MAX = DEF_STREAK_MAX
) (
    input logic       clk,
    input logic       n_rst,
    ula_dram_if.slave bus
);
    localparam int HW = AW / 2;

    logic          cpu_req, rfsh_req, n_rfsh_eff, decide;
    cycle_t        grant;
    state_t        state_q, state_d;
    cycle_t        type_q, type_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [HW-1:0] ma_q, ma_d;
    logic          n_ras_q, n_ras_d, n_cas_q, n_cas_d, n_we_q, n_we_d;
    logic          vid_ack_q, vid_ack_d, vid_strobe_q, vid_strobe_d;
    logic          cpu_strobe_q, cpu_strobe_d, cpu_wait_q, cpu_wait_d;

`ifdef ULA_DRAM_REFRESH_EN
    assign n_rfsh_eff = bus.n_rfsh;
    assign rfsh_req   = !bus.n_mreq && !bus.n_rfsh;
`else
    logic unused_n_rfsh;
    assign unused_n_rfsh = bus.n_rfsh;
    assign n_rfsh_eff    = 1'b1;
    assign rfsh_req      = 1'b0;
`endif

    assign cpu_req = !bus.n_mreq && bus.cpu_ram_sel && (!bus.n_rd || !bus.n_wr) && n_rfsh_eff;
    assign decide  = (state_q == IDLE) || (state_q == PRE);

    ula_dram_grant #(.STREAK_MAX(STREAK_MAX)) u_grant (
        .clk      (clk),
        .n_rst    (n_rst),
        .decide   (decide),
        .vid_req  (bus.vid_req),
        .cpu_req  (cpu_req),
        .cpu_wr   (!bus.n_wr),
        .rfsh_req (rfsh_req),
        .grant    (grant)
    );

    // sequencer: next state, then the pad values for the state being entered
    always_comb begin
        state_d      = state_q;
        type_d       = type_q;
        addr_d       = addr_q;
        ma_d         = ma_q;
        n_ras_d      = 1'b1;
        n_cas_d      = 1'b1;
        n_we_d       = 1'b1;
        vid_ack_d    = 1'b0;
        vid_strobe_d = 1'b0;
        cpu_strobe_d = 1'b0;

        case (state_q)
            IDLE, PRE: begin
                if (grant != CYC_NONE) begin
                    state_d = ROW;
                    type_d  = grant;
                    addr_d  = (grant == CYC_VID) ? bus.vid_addr : bus.cpu_addr;
                end else begin
                    state_d = IDLE;
                    type_d  = CYC_NONE;
                end
            end
            ROW:     state_d = RAS;
            RAS:     state_d = CAS1;
            CAS1:    state_d = CAS2;
            CAS2:    state_d = PRE;
            default: state_d = IDLE;
        endcase

        case (state_d)
            ROW: begin
                ma_d      = addr_d[HW-1:0];
                vid_ack_d = (type_d == CYC_VID);
            end
            RAS: begin
                ma_d    = addr_d[HW-1:0];
                n_ras_d = 1'b0;
                n_we_d  = (type_d != CYC_CPU_WR);
            end
            CAS1, CAS2: begin
                // refresh keeps the row on the pads and never strobes CAS
                ma_d    = (type_d == CYC_RFSH) ? addr_d[HW-1:0] : addr_d[AW-1:HW];
                n_ras_d = 1'b0;
                n_cas_d = (type_d == CYC_RFSH);
                n_we_d  = (type_d != CYC_CPU_WR);
                if (state_d == CAS2) begin
                    vid_strobe_d = (type_d == CYC_VID);
                    cpu_strobe_d = is_cpu(type_d);
                end
            end
            default: ; // IDLE/PRE: strobes high, ma holds
        endcase

        // stall the CPU while it asks but does not own the bank
        cpu_wait_d = cpu_req &&
                     !(is_cpu(type_d) && (state_d inside {ROW, RAS, CAS1, CAS2}));
    end

    // state and registered pads; reset aborts any cycle in flight
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            type_q       <= CYC_NONE;
            addr_q       <= '0;
            ma_q         <= '0;
            n_ras_q      <= 1'b1;
            n_cas_q      <= 1'b1;
            n_we_q       <= 1'b1;
            vid_ack_q    <= 1'b0;
            vid_strobe_q <= 1'b0;
            cpu_strobe_q <= 1'b0;
            cpu_wait_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            type_q       <= type_d;
            addr_q       <= addr_d;
            ma_q         <= ma_d;
            n_ras_q      <= n_ras_d;
            n_cas_q      <= n_cas_d;
            n_we_q       <= n_we_d;
            vid_ack_q    <= vid_ack_d;
            vid_strobe_q <= vid_strobe_d;
            cpu_strobe_q <= cpu_strobe_d;
            cpu_wait_q   <= cpu_wait_d;
        end
    end

    assign bus.ma         = ma_q;
    assign bus.n_ras      = n_ras_q;
    assign bus.n_cas      = n_cas_q;
    assign bus.n_we       = n_we_q;
    assign bus.vid_ack    = vid_ack_q;
    assign bus.vid_strobe = vid_strobe_q;
    assign bus.cpu_strobe = cpu_strobe_q;
    assign bus.cpu_wait   = cpu_wait_q;

endmodule

// File: tb/tb_ula_dram_arbiter.sv
// tb_ula_dram_arbiter: directed stimulus with a cycle scoreboard. Each
// expected DRAM cycle (kind,row,col) is queued when its request is driven
// and compared when the DUT closes that cycle (n_ras rising).
module tb_ula_dram_arbiter;
    import ula_dram_pkg::*;

    localparam int AW = 14;
    localparam int HW = AW / 2;
    localparam logic [1:0] K_RFSH = 2'd0, K_VID = 2'd1, K_RD = 2'd2, K_WR = 2'd3;
    localparam logic [31:0] RST_OUTS = 32'h3800; // n_ras/n_cas/n_we=1, rest 0
`ifdef ULA_DRAM_REFRESH_EN
    localparam int RFSH_RAS_CLKS = 3;
`else
    localparam int RFSH_RAS_CLKS = 0;
`endif

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    ula_dram_if #(.AW(AW)) bus ();

    ula_dram_arbiter #(.AW(AW), .STREAK_MAX(2)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] outs();
        return 32'({bus.n_ras, bus.n_cas, bus.n_we, bus.cpu_wait,
                    bus.vid_ack, bus.vid_strobe, bus.cpu_strobe, bus.ma});
    endfunction

    // expected cycle record: kind, row on RAS, column on CAS (row for refresh)
    logic [15:0] sb_q[$];
    function automatic logic [15:0] sb_ent(input logic [1:0] k, input logic [AW-1:0] a);
        logic [HW-1:0] row, col;
        row = a % (1 << HW);
        col = a / (1 << HW);
        return {k, row, (k == K_RFSH) ? row : col};
    endfunction

    // monitor: reconstruct each DRAM cycle from the pads
    initial begin
        logic          prev_ras;
        logic [1:0]    o_kind;
        logic [HW-1:0] o_row, o_col;
        prev_ras = 1'b1;
        o_kind   = K_RFSH;
        o_row    = '0;
        o_col    = '0;
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                prev_ras = 1'b1;
            end else begin
                if (prev_ras && !bus.n_ras) begin
                    o_kind = K_RFSH;
                    o_row  = bus.ma;
                    o_col  = bus.ma;
                end
                if (!bus.n_cas) o_col = bus.ma;
                if (bus.vid_strobe) o_kind = K_VID;
                if (bus.cpu_strobe) o_kind = bus.n_we ? K_RD : K_WR;
                if (!prev_ras && bus.n_ras) begin
                    chk("sb_pending", 32'(sb_q.size() != 0), 32'd1);
                    if (sb_q.size() != 0)
                        chk("sb_cycle", 32'({o_kind, o_row, o_col}), 32'(sb_q.pop_front()));
                end
                prev_ras = bus.n_ras;
            end
        end
    end

    task automatic cpu_drive(input logic [AW-1:0] a, input logic wr);
        bus.cpu_addr    = a;
        bus.cpu_ram_sel = 1'b1;
        bus.n_mreq      = 1'b0;
        bus.n_rd        = wr;
        bus.n_wr        = !wr;
    endtask

    task automatic cpu_release();
        bus.n_mreq      = 1'b1;
        bus.n_rd        = 1'b1;
        bus.n_wr        = 1'b1;
        bus.cpu_ram_sel = 1'b0;
    endtask

    // per-phase trace of an uncontended CPU access; index 0 = ROW
    logic [HW-1:0] tr_ma [8];
    logic [7:0]    tr_ras, tr_cas, tr_we, tr_stb, tr_wait;

    task automatic run_cpu(input logic [AW-1:0] a, input logic wr);
        @(negedge clk);
        cpu_drive(a, wr);
        sb_q.push_back(sb_ent(wr ? K_WR : K_RD, a));
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            tr_ma[i]   = bus.ma;
            tr_ras[i]  = bus.n_ras;
            tr_cas[i]  = bus.n_cas;
            tr_we[i]   = bus.n_we;
            tr_stb[i]  = bus.cpu_strobe;
            tr_wait[i] = bus.cpu_wait;
            if (bus.cpu_strobe) cpu_release();
        end
    endtask

    initial begin
        int          t, acks, cstb, stb_at, ras_lo, cas_lo, wait_hi, ma_bad;
        logic [15:0] wtr;
        logic [5:0]  order;

        bus.vid_req     = 1'b0;
        bus.vid_addr    = '0;
        bus.n_mreq      = 1'b1;
        bus.n_rd        = 1'b1;
        bus.n_wr        = 1'b1;
        bus.n_rfsh      = 1'b1;
        bus.cpu_ram_sel = 1'b0;
        bus.cpu_addr    = '0;
        n_rst           = 1'b0;

        // power-on reset
        #12;
        chk("rst_idle", outs(), RST_OUTS);
        @(negedge clk);
        n_rst = 1'b1;

        // reset asserted in the middle of RAS of a CPU read
        @(negedge clk);
        cpu_drive(14'h1234, 1'b0);
        t = 0;
        while (bus.n_ras && t < 8) begin
            @(negedge clk);
            t++;
        end
        chk("rst_reach_ras", 32'(bus.n_ras), 32'd0);
        #2 n_rst = 1'b0;
        #1 chk("rst_mid_ras", outs(), RST_OUTS);
        cpu_release();
        @(negedge clk);
        chk("rst_hold", outs(), RST_OUTS);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        // CPU read 0x1234
        run_cpu(14'h1234, 1'b0);
        chk("rd_ma_row",  32'(tr_ma[0]), 32'h34);
        chk("rd_ma_ras",  32'(tr_ma[1]), 32'h34);
        chk("rd_ma_cas1", 32'(tr_ma[2]), 32'h24);
        chk("rd_ma_pre",  32'(tr_ma[4]), 32'h24);
        chk("rd_n_ras",   32'(tr_ras),   32'hF1);
        chk("rd_n_cas",   32'(tr_cas),   32'hF3);
        chk("rd_n_we",    32'(tr_we),    32'hFF);
        chk("rd_strobe",  32'(tr_stb),   32'h08);
        chk("rd_wait",    32'(tr_wait),  32'h00);

        // CPU write 0x3FFF
        run_cpu(14'h3FFF, 1'b1);
        chk("wr_ma_row",  32'(tr_ma[0]), 32'h7F);
        chk("wr_ma_cas1", 32'(tr_ma[2]), 32'h7F);
        chk("wr_n_we",    32'(tr_we),    32'hF1);
        chk("wr_strobes", 32'($countones(tr_stb)), 32'd1);

        // video and CPU requested on the same edge from IDLE
        @(negedge clk);
        bus.vid_addr = 14'h0ABC;
        bus.vid_req  = 1'b1;
        cpu_drive(14'h0155, 1'b0);
        sb_q.push_back(sb_ent(K_VID, 14'h0ABC));
        sb_q.push_back(sb_ent(K_RD, 14'h0155));
        wtr    = '0;
        stb_at = -1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            wtr[i] = bus.cpu_wait;
            if (bus.vid_ack) bus.vid_req = 1'b0;
            if (bus.cpu_strobe) begin
                stb_at = i;
                cpu_release();
            end
        end
        chk("sim_wait_trace", 32'(wtr), 32'h001F);
        chk("sim_cpu_strobe", 32'(stb_at), 32'd8);

        // CPU request withdrawn while video owns the bank: no CPU cycle
        @(negedge clk);
        bus.vid_addr = 14'h2001;
        bus.vid_req  = 1'b1;
        sb_q.push_back(sb_ent(K_VID, 14'h2001));
        @(negedge clk);
        chk("drop_vid_ack", 32'(bus.vid_ack), 32'd1);
        bus.vid_req = 1'b0;
        cpu_drive(14'h0222, 1'b1);
        @(negedge clk);
        chk("drop_wait", 32'(bus.cpu_wait), 32'd1);
        cpu_release();
        ras_lo = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (!bus.n_ras) ras_lo++;
        end
        chk("drop_ras_clks", 32'(ras_lo), 32'd2);

        // video held with a CPU request pending: V V C V V C
        @(negedge clk);
        bus.vid_addr = 14'h1555;
        bus.vid_req  = 1'b1;
        cpu_drive(14'h0ACE, 1'b0);
        sb_q.push_back(sb_ent(K_VID, 14'h1555));
        sb_q.push_back(sb_ent(K_VID, 14'h1555));
        sb_q.push_back(sb_ent(K_RD,  14'h0ACE));
        sb_q.push_back(sb_ent(K_VID, 14'h1555));
        sb_q.push_back(sb_ent(K_VID, 14'h1555));
        sb_q.push_back(sb_ent(K_RD,  14'h0ACE));
        acks  = 0;
        cstb  = 0;
        order = '0;
        t     = 0;
        for (int i = 0; i < 40 && cstb < 2; i++) begin
            @(negedge clk);
            if (bus.vid_ack) acks++;
            if (bus.vid_strobe && t < 6) begin
                order[t] = 1'b0;
                t++;
            end
            if (bus.cpu_strobe) begin
                if (t < 6) begin
                    order[t] = 1'b1;
                    t++;
                end
                cstb++;
                if (cstb == 2) begin
                    cpu_release();
                    bus.vid_req = 1'b0;
                end
            end
        end
        chk("seq_cpu_cycles", 32'(cstb),  32'd2);
        chk("seq_vid_acks",   32'(acks),  32'd4);
        chk("seq_order",      32'(order), 32'b100100);
        repeat (3) @(negedge clk);

        // refresh MREQ with cpu_addr = 0x0015
        @(negedge clk);
        bus.cpu_addr    = 14'h0015;
        bus.cpu_ram_sel = 1'b1;
        bus.n_mreq      = 1'b0;
        bus.n_rfsh      = 1'b0;
`ifdef ULA_DRAM_REFRESH_EN
        sb_q.push_back(sb_ent(K_RFSH, 14'h0015));
`endif
        ras_lo  = 0;
        cas_lo  = 0;
        wait_hi = 0;
        ma_bad  = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.cpu_wait) wait_hi++;
            if (!bus.n_cas) cas_lo++;
            if (!bus.n_ras) begin
                ras_lo++;
                if (bus.ma != 7'h15) ma_bad++;
            end
            if (i == 0) begin
                bus.n_mreq      = 1'b1;
                bus.n_rfsh      = 1'b1;
                bus.cpu_ram_sel = 1'b0;
            end
        end
        chk("rfsh_ras_clks", 32'(ras_lo),  32'(RFSH_RAS_CLKS));
        chk("rfsh_n_cas",    32'(cas_lo),  32'd0);
        chk("rfsh_wait",     32'(wait_hi), 32'd0);
        chk("rfsh_ma",       32'(ma_bad),  32'd0);

        repeat (4) @(negedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule
